// File: rtl/ofmap_packetizer.sv
// ofmap_packetizer: turns ofmap spike rows into one NOC packet per spike plus a per-timestep DONE packet
module ofmap_packetizer #(
    parameter logic [3:0] SRC_ADDR  = 4'b0001,
    parameter logic [3:0] DEST_ADDR = 4'b0000,
    parameter int         NUM_COLS  = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                row_valid,
    output logic                row_ready,
    input  logic [4:0]          row_idx,
    input  logic [NUM_COLS-1:0] row_spikes,
    input  logic                row_last,
    output logic                pkt_valid,
    input  logic                pkt_ready,
    output logic [63:0]         pkt_data,
    output logic [7:0]          ts_count,
    output logic [15:0]         spike_count,
    output logic                row_err
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE_PKT} stateT;

    localparam logic [53:0] HDR = {DEST_ADDR, SRC_ADDR, 2'b11, 44'd0};

    stateT                state, stateNext;
    logic [NUM_COLS-1:0]  mask, maskNext;
    logic [4:0]           rowReg, rowNext;
    logic                 lastReg, lastNext;
    logic                 started, errNext, rowFire, pktFire, pktValidNext;
    logic [63:0]          pktDataNext;

    function automatic logic [4:0] lowestBit(input logic [NUM_COLS-1:0] m);
        lowestBit = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--)
            if (m[i]) lowestBit = 5'(i);
    endfunction

    assign row_ready = started && state == IDLE;
    assign rowFire   = row_valid && row_ready;
    assign pktFire   = pkt_valid && pkt_ready;

    // next state, mask and the packet to present next cycle (computed from the post-edge state so pkt_valid is registered)
    always_comb begin
        stateNext = state;
        maskNext  = mask;
        rowNext   = rowReg;
        lastNext  = lastReg;
        errNext   = row_err;
        case (state)
            IDLE: if (rowFire) begin
                if (32'(row_idx) < NUM_COLS) begin
                    maskNext  = row_spikes;
                    rowNext   = row_idx;
                    lastNext  = row_last;
                    stateNext = SCAN;
                end else begin
                    errNext = 1'b1;
                end
            end
            SCAN: if (mask == '0) begin
                stateNext = lastReg ? DONE_PKT : IDLE;
            end else if (pktFire) begin
                maskNext = mask & (mask - NUM_COLS'(1));
                if (maskNext == '0) stateNext = lastReg ? DONE_PKT : IDLE;
            end
            DONE_PKT: if (pktFire) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        pktValidNext = (stateNext == SCAN && maskNext != '0) || stateNext == DONE_PKT;
        pktDataNext  = !pktValidNext ? '0 :
                       stateNext == DONE_PKT ? {HDR, 10'h1FF} : {HDR, rowNext, lowestBit(maskNext)};
    end

    // state, packet register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '0;
            rowReg      <= '0;
            lastReg     <= 1'b0;
            started     <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_data    <= '0;
            ts_count    <= '0;
            spike_count <= '0;
            row_err     <= 1'b0;
        end else begin
            state     <= stateNext;
            mask      <= maskNext;
            rowReg    <= rowNext;
            lastReg   <= lastNext;
            started   <= 1'b1;
            pkt_valid <= pktValidNext;
            pkt_data  <= pktDataNext;
            row_err   <= errNext;
            if (pktFire && state == SCAN && spike_count != 16'hFFFF)
                spike_count <= spike_count + 16'd1;
            if (pktFire && state == DONE_PKT) begin
                ts_count    <= ts_count + 8'd1;
                spike_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ofmap_packetizer.sv
// tb_ofmap_packetizer: scoreboard bench for the ofmap packetizer
module tb_ofmap_packetizer;
    localparam logic [63:0] HDR = 64'h01C0_0000_0000_0000;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        row_valid = 0;
    logic        row_ready;
    logic [4:0]  row_idx = '0;
    logic [20:0] row_spikes = '0;
    logic        row_last = 0;
    logic        pkt_valid;
    logic        pkt_ready = 0;
    logic [63:0] pkt_data;
    logic [7:0]  ts_count;
    logic [15:0] spike_count;
    logic        row_err;

    int tests = 0;
    int fails = 0;
    logic [63:0] expQ[$];
    logic        prevHold = 0;
    logic [63:0] prevData = '0;

    ofmap_packetizer dut (
        .clk(clk), .rst_n(rst_n), .row_valid(row_valid), .row_ready(row_ready),
        .row_idx(row_idx), .row_spikes(row_spikes), .row_last(row_last),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .ts_count(ts_count), .spike_count(spike_count), .row_err(row_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [9:0] low);
        return HDR | 64'(low);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every packet transfer and checks held packets stay stable
    always @(negedge clk) begin
        if (!rst_n) begin
            prevHold = 0;
        end else begin
            if (prevHold) begin
                check("hold_valid", 64'(pkt_valid), 64'd1);
                check("hold_data", pkt_data, prevData);
            end
            if (pkt_valid && pkt_ready) begin
                if (expQ.size() == 0) check("unexpected_pkt", pkt_data, 64'd0 - 64'd1);
                else check("pkt_data", pkt_data, expQ.pop_front());
            end
            prevHold = pkt_valid && !pkt_ready;
            prevData = pkt_data;
        end
    end

    task automatic sendRow(input logic [4:0] idx, input logic [20:0] spk, input logic last);
        int n = 0;
        while (!row_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!row_ready) begin
            check("row_accept_wait", 64'(row_ready), 64'd1);
            return;
        end
        row_valid = 1; row_idx = idx; row_spikes = spk; row_last = last;
        @(posedge clk); #1;
        row_valid = 0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((expQ.size() != 0 || !row_ready) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check(name, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_ready", 64'(row_ready), 64'd0);
        check("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        rst_n = 1;
        @(posedge clk); #1;
        check("idle_row_ready", 64'(row_ready), 64'd1);
        check("idle_pkt_valid", 64'(pkt_valid), 64'd0);
        check("idle_ts", 64'(ts_count), 64'd0);
        check("idle_spk", 64'(spike_count), 64'd0);
        check("idle_err", 64'(row_err), 64'd0);

        // row 3, columns 0 and 20, last row, NOC always ready
        pkt_ready = 1;
        expQ.push_back(pk(10'h060));
        expQ.push_back(pk(10'h074));
        expQ.push_back(pk(10'h1FF));
        sendRow(5'd3, 21'h100001, 1);
        check("first_pkt_latency", 64'(pkt_valid), 64'd1);
        check("row_ready_busy", 64'(row_ready), 64'd0);
        @(posedge clk); #1;
        check("spk_after_1", 64'(spike_count), 64'd1);
        @(posedge clk); #1;
        check("spk_before_done", 64'(spike_count), 64'd2);
        @(posedge clk); #1;
        check("back_to_back", 64'(expQ.size()), 64'd0);
        check("ts_after_row3", 64'(ts_count), 64'd1);
        check("spk_cleared", 64'(spike_count), 64'd0);

        // all-zero last row: one empty SCAN cycle, then only DONE
        expQ.push_back(pk(10'h1FF));
        sendRow(5'd20, 21'h0, 1);
        check("zero_row_scan", 64'(pkt_valid), 64'd0);
        waitIdle("drain_zero_row");
        check("ts_after_zero", 64'(ts_count), 64'd2);

        // row 7, columns 1/5/9 with 5 stalled cycles per packet
        pkt_ready = 0;
        expQ.push_back(pk(10'h0E1));
        expQ.push_back(pk(10'h0E5));
        expQ.push_back(pk(10'h0E9));
        expQ.push_back(pk(10'h1FF));
        sendRow(5'd7, 21'h000222, 1);
        for (int k = 0; k < 4; k++) begin
            repeat (5) @(posedge clk);
            #1;
            if (k == 3) check("spk_before_done_bp", 64'(spike_count), 64'd3);
            pkt_ready = 1;
            @(posedge clk); #1;
            pkt_ready = 0;
        end
        check("drain_bp", 64'(expQ.size()), 64'd0);
        check("ts_after_bp", 64'(ts_count), 64'd3);
        check("spk_after_bp", 64'(spike_count), 64'd0);

        // illegal row index is dropped and flagged; its row_last is ignored
        pkt_ready = 1;
        sendRow(5'd21, 21'h1FFFFF, 1);
        check("err_set", 64'(row_err), 64'd1);
        check("err_idle", 64'(row_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("err_no_pkt", 64'(pkt_valid), 64'd0);
        check("err_ts", 64'(ts_count), 64'd3);
        expQ.push_back(pk(10'h044));
        sendRow(5'd2, 21'h000010, 0);
        waitIdle("drain_after_err");
        check("ts_not_last", 64'(ts_count), 64'd3);
        check("err_sticky", 64'(row_err), 64'd1);

        // reset asserted while the 2nd of 4 packets is presented
        expQ.push_back(pk(10'h0A0));
        sendRow(5'd5, 21'h00000F, 1);
        @(posedge clk); #1;
        pkt_ready = 0;
        check("mid_pkt2_valid", 64'(pkt_valid), 64'd1);
        check("mid_pkt2_data", pkt_data, pk(10'h0A1));
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("async_rst_valid", 64'(pkt_valid), 64'd0);
        check("async_rst_ready", 64'(row_ready), 64'd0);
        check("async_rst_ts", 64'(ts_count), 64'd0);
        check("async_rst_spk", 64'(spike_count), 64'd0);
        check("async_rst_err", 64'(row_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        pkt_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_ready", 64'(row_ready), 64'd1);
        check("post_rst_valid", 64'(pkt_valid), 64'd0);
        check("scoreboard_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ofmap_packetizer.md
OFMAP_PACKETIZER -- requirements
Module: ofmap_packetizer

Interface
REQ-001 The block SHALL have parameter SRC_ADDR, default 4'b0001, giving the PE address placed in packet bits [59:56].
REQ-002 The block SHALL have parameter DEST_ADDR, default 4'b0000, giving the memory-interface address placed in packet bits [63:60].
REQ-003 The block SHALL have parameter NUM_COLS, default 21, giving the ofmap row width in spikes.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port row_valid, input, 1 bit: an ofmap row is offered.
REQ-008 The block SHALL have port row_ready, output, 1 bit: the block accepts a row.
REQ-009 The block SHALL have port row_idx, input, 5 bits: ofmap row number.
REQ-010 The block SHALL have port row_spikes, input, NUM_COLS bits: bit c = output spike at column c.
REQ-011 The block SHALL have port row_last, input, 1 bit: last row of the current timestep.
REQ-012 The block SHALL have port pkt_valid, output, 1 bit: a NOC packet is presented.
REQ-013 The block SHALL have port pkt_ready, input, 1 bit: the NOC accepts the packet.
REQ-014 The block SHALL have port pkt_data, output, 64 bits: NOC packet.
REQ-015 The block SHALL have port ts_count, output, 8 bits: number of completed timesteps.
REQ-016 The block SHALL have port spike_count, output, 16 bits: spike packets sent in the current timestep.
REQ-017 The block SHALL have port row_err, output, 1 bit: sticky flag for an illegal row index.

Function
REQ-018 Handshakes SHALL be valid/ready: transfer iff valid and ready are high on the same rising edge.
REQ-019 Once pkt_valid is high, pkt_valid and pkt_data SHALL hold stable until the transfer.
REQ-020 The FSM SHALL have states IDLE, SCAN and DONE_PKT.
REQ-021 row_ready SHALL be high only in IDLE.
REQ-022 IDLE: on a row transfer with row_idx < NUM_COLS, the block SHALL latch row_spikes into mask, latch row_idx and row_last, and go to SCAN.
REQ-023 IDLE: on a row transfer with row_idx >= NUM_COLS, the block SHALL drop the row, set row_err, and stay in IDLE; row_last of the dropped row SHALL be ignored.
REQ-024 SCAN with mask nonzero: the block SHALL present a spike packet for the lowest set bit c of mask.
REQ-025 Spike packet format: [63:60]=DEST_ADDR, [59:56]=SRC_ADDR, [55:54]=2'b11, [53:10]=0, [9:5]=row, [4:0]=c.
REQ-026 On each spike-packet transfer, the block SHALL clear bit c of mask and increment spike_count, saturating at 16'hFFFF.
REQ-027 The next set bit SHALL be presented in the following cycle, giving 1 packet per cycle under continuous pkt_ready.
REQ-028 SCAN with mask zero: the block SHALL go to DONE_PKT if the latched row_last is 1, else to IDLE, with no packet; an all-zero row SHALL cost one SCAN cycle.
REQ-029 DONE_PKT: the block SHALL present a DONE packet: [63:60]=DEST_ADDR, [59:56]=SRC_ADDR, [55:54]=2'b11, [53:10]=0, [9:0]=10'h1FF.
REQ-030 On DONE-packet transfer, the block SHALL increment ts_count (wrapping 8'hFF to 0), clear spike_count to 0, and go to IDLE.
REQ-031 The DONE column field (31) SHALL never collide with a spike packet, since c <= NUM_COLS-1.
REQ-032 pkt_valid SHALL be driven from registers; the first spike packet of a row SHALL appear at the cycle after the row transfer.
REQ-033 The block SHALL accept no new row until the current row, including its DONE packet, completes.

Reset
REQ-034 On rst_n low, at any time including mid-SCAN or mid-DONE_PKT, the block SHALL asynchronously go to IDLE with mask=0, pkt_valid=0, pkt_data=0, row_ready=0, ts_count=0, spike_count=0 and row_err=0.
REQ-035 Any partially sent row SHALL be discarded on reset.
REQ-036 row_ready SHALL rise in the first clock cycle after rst_n deasserts.

Verification
REQ-037 Reset then idle -> row_ready=1, pkt_valid=0, all counters 0, row_err=0.
REQ-038 Row idx=3, spikes bits 0 and 20 set, last=1, pkt_ready=1 -> packets with [9:0]=0x060, then 0x074, then DONE [9:0]=0x1FF on consecutive cycles; ts_count=1; spike_count back to 0.
REQ-039 All-zero row idx=20, last=1 -> only the DONE packet is sent; ts_count increments.
REQ-040 Three-bit row with pkt_ready low 5 cycles per packet -> each packet is held stable, none lost or duplicated, spike_count=3 before DONE.
REQ-041 Row idx=21 -> row_err=1, no packets, the FSM stays in IDLE; the next legal row is processed normally.
REQ-042 rst_n pulsed low during the 2nd of 4 packets -> pkt_valid=0 immediately, no further packets of that row, counters 0.
